lse_clut_interp: RTL and testbench
==================================

// Module: lse_clut_interp
// PURPOSE
// Programmable LSE correction LUT, parametrised successor of the fixed 16-entry CLUT.
// Table is runtime-loadable; lookups use nearest-lower or linear-interpolated mode.
// 3-stage pipeline with valid/ready flow control and a pass-through tag.
// Sits between the LSE difference computation and the final correction adder in the PE.
// PARAMETERS
// ADDR_BITS    4   table index width; ENTRIES = 2**ADDR_BITS
// FRAC_BITS    4   fractional bits of lookup input used for interpolation (>=1)
// ENTRY_WIDTH  10  unsigned table entry / correction output width
// TAG_W        4   sideband tag width, carried unchanged input->output
// PORTS
// clk          in   1                    clock, all logic on rising edge
// rst          in   1                    synchronous reset, active-high
// cfg_we       in   1                    table write strobe
// cfg_addr     in   ADDR_BITS            table write index
// cfg_wdata    in   ENTRY_WIDTH          table write data
// in_valid     in   1                    lookup request valid
// in_ready     out  1                    lookup request accepted when in_valid&&in_ready
// in_x         in   ADDR_BITS+FRAC_BITS  lookup input {idx, frac}
// in_mode      in   1                    0 = nearest-lower (T[idx]), 1 = linear interpolation
// in_tag       in   TAG_W                sideband tag
// out_valid    out  1                    correction valid
// out_ready    in   1                    downstream accepts when out_valid&&out_ready
// correction   out  ENTRY_WIDTH          correction result
// out_tag      out  TAG_W                tag of this result
// BEHAVIOUR
// - Reset (rst=1 at clk edge): all table entries <= 0; all stage valids, out_valid, correction,
//   out_tag <= 0. In-flight lookups discarded. in_ready is 1 in the cycle after reset.
// - Table: ENTRIES x ENTRY_WIDTH registers. cfg_we=1 writes T[cfg_addr] at the edge; always
//   accepted, no backpressure. Lookup sampling T in the same cycle as a write to that index
//   reads the OLD value; lookups accepted the following cycle see the new value.
// - Pipeline enable: en = !out_valid || out_ready; in_ready = en (global stall, no bubble collapse).
//   When en=0 every stage register holds; when en=1 all stages advance together.
// - S1 (on en): capture v1=in_valid, idx=in_x[top ADDR_BITS], frac=in_x[FRAC_BITS-1:0], mode, tag,
//   y0=T[idx], y1=(idx==ENTRIES-1) ? T[idx] : T[idx+1]  (clamp at top, never wrap to T[0]).
// - S2: d = signed(y1) - signed(y0), ENTRY_WIDTH+1 bits; p = d * frac, ENTRY_WIDTH+FRAC_BITS+1 bits signed.
// - S3: mode0: correction = y0. mode1: correction = y0 + ((p + 2**(FRAC_BITS-1)) >>> FRAC_BITS)
//   (arithmetic shift, round-half-up). Result always in [min(y0,y1),max(y0,y1)]; no saturation needed.
// - Latency: request accepted at edge N -> out_valid=1 after edge N+3 when no stall; throughput 1/cycle.
// - out_valid/correction/out_tag stable while out_valid && !out_ready; order strictly preserved.
// - frac=0 in mode1 yields exactly y0. Bubbles (in_valid=0 with en=1) propagate as invalid slots.
// - Simultaneous cfg write and stall: write still performed; stalled S1 contents keep captured values.
// TESTING (ADDR_BITS=4, FRAC_BITS=4, ENTRY_WIDTH=10)
// 1 Program T[2]=0x3C0,T[3]=0x3A2; in_x=0x28,mode=1,tag=5 -> 3 cycles later correction=0x3B1 (945), out_tag=5.
// 2 Same table, in_x=0x28,mode=0 -> correction=0x3C0; in_x=0x20,mode=1 -> 0x3C0.
// 3 T[15]=0x26C,T[0]=0x3FF; in_x=0xFF,mode=1 -> correction=0x26C (clamp, no wrap to T[0]).
// 4 Stream 4 lookups tags 1..4, hold out_ready=0 for 5 cycles -> in_ready=0, output frozen, then
//   tags 1,2,3,4 delivered in order, none lost or duplicated.
// 5 cfg write T[2]=0x100 in same cycle as accepted lookup in_x=0x20,mode=0 -> result 0x3C0; next lookup -> 0x100.
// 6 Assert rst mid-stream with 3 lookups in flight -> out_valid=0 next cycle, no results emerge,
//   any subsequent lookup returns 0 until table reprogrammed.

Source files
------------

// File: rtl/lse_clut_interp.sv
// Runtime-loadable LSE correction LUT with nearest-lower or linear-interpolated lookup.
// Four register ranks (S1 fetch, S2 difference, S3 product, output) under one global stall.
module lse_clut_interp #(
    parameter int ADDR_BITS   = 4,
    parameter int FRAC_BITS   = 4,
    parameter int ENTRY_WIDTH = 10,
    parameter int TAG_W       = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [ADDR_BITS-1:0]           cfg_addr,
    input  logic [ENTRY_WIDTH-1:0]         cfg_wdata,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ADDR_BITS+FRAC_BITS-1:0] in_x,
    input  logic                           in_mode,
    input  logic [TAG_W-1:0]               in_tag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ENTRY_WIDTH-1:0]         correction,
    output logic [TAG_W-1:0]               out_tag
);

    localparam int ENTRIES = 2 ** ADDR_BITS;
    localparam int XW      = ADDR_BITS + FRAC_BITS;
    localparam int DW      = ENTRY_WIDTH + 1;
    localparam int PW      = ENTRY_WIDTH + FRAC_BITS + 1;
    localparam logic signed [PW-1:0] HALF = PW'(2 ** (FRAC_BITS - 1));

    logic [ENTRY_WIDTH-1:0] lut [ENTRIES];

    // S1 registers
    logic                   v1, mode1;
    logic [TAG_W-1:0]       tag1;
    logic [FRAC_BITS-1:0]   frac1;
    logic [ENTRY_WIDTH-1:0] y0_1, y1_1;
    // S2 registers
    logic                   v2, mode2;
    logic [TAG_W-1:0]       tag2;
    logic [FRAC_BITS-1:0]   frac2;
    logic [ENTRY_WIDTH-1:0] y0_2;
    logic signed [DW-1:0]   d2;
    // S3 registers
    logic                   v3, mode3;
    logic [TAG_W-1:0]       tag3;
    logic [ENTRY_WIDTH-1:0] y0_3;
    logic signed [PW-1:0]   p3;

    logic                   en;
    logic [ADDR_BITS-1:0]   idx, idx_hi;
    logic [FRAC_BITS-1:0]   frac_in;
    logic signed [DW-1:0]   d_c;
    logic signed [PW-1:0]   d_ext, f_ext, p_c, p_rnd, delta, sum_c;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign idx      = in_x[XW-1:FRAC_BITS];
    assign frac_in  = in_x[FRAC_BITS-1:0];
    // Upper neighbour clamps at the last entry instead of wrapping to entry 0.
    assign idx_hi   = (idx == ADDR_BITS'(ENTRIES - 1)) ? idx : idx + ADDR_BITS'(1);

    always_comb begin
        d_c   = $signed({1'b0, y1_1}) - $signed({1'b0, y0_1});
        d_ext = {{(PW - DW){d2[DW-1]}}, d2};
        f_ext = {{(PW - FRAC_BITS){1'b0}}, frac2};
        p_c   = d_ext * f_ext;
        p_rnd = p3 + HALF;
        delta = p_rnd >>> FRAC_BITS;
        sum_c = $signed({{(PW - ENTRY_WIDTH){1'b0}}, y0_3}) + delta;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table is a register file, not a RAM, so it is cleared on reset like any other state.
            for (int i = 0; i < ENTRIES; i++) lut[i] <= '0;
            v1 <= 1'b0; mode1 <= 1'b0; tag1 <= '0; frac1 <= '0; y0_1 <= '0; y1_1 <= '0;
            v2 <= 1'b0; mode2 <= 1'b0; tag2 <= '0; frac2 <= '0; y0_2 <= '0; d2 <= '0;
            v3 <= 1'b0; mode3 <= 1'b0; tag3 <= '0; y0_3 <= '0; p3 <= '0;
            out_valid  <= 1'b0;
            correction <= '0;
            out_tag    <= '0;
        end else begin
            // NOTE: non-blocking write means a lookup in the same cycle reads the old entry.
            if (cfg_we) lut[cfg_addr] <= cfg_wdata;
            if (en) begin
                v1    <= in_valid;
                mode1 <= in_mode;
                tag1  <= in_tag;
                frac1 <= frac_in;
                y0_1  <= lut[idx];
                y1_1  <= lut[idx_hi];

                v2    <= v1;
                mode2 <= mode1;
                tag2  <= tag1;
                frac2 <= frac1;
                y0_2  <= y0_1;
                d2    <= d_c;

                v3    <= v2;
                mode3 <= mode2;
                tag3  <= tag2;
                y0_3  <= y0_2;
                p3    <= p_c;

                out_valid  <= v3;
                out_tag    <= tag3;
                // Interpolated result lies between y0 and y1, so truncation cannot overflow.
                correction <= mode3 ? sum_c[ENTRY_WIDTH-1:0] : y0_3;
            end
        end
    end

endmodule

// File: tb/tb_lse_clut_interp.sv
// Directed scoreboard bench for lse_clut_interp: stimulus pushes expectations, a monitor pops them.
module tb_lse_clut_interp;

    localparam int AB = 4;
    localparam int FB = 4;
    localparam int EW = 10;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [AB-1:0] cfg_addr;
    logic [EW-1:0] cfg_wdata;
    logic          in_valid;
    logic          in_ready;
    logic [AB+FB-1:0] in_x;
    logic          in_mode;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] correction;
    logic [TW-1:0] out_tag;

    typedef struct packed {
        logic [EW-1:0] corr;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    lse_clut_interp #(.ADDR_BITS(AB), .FRAC_BITS(FB), .ENTRY_WIDTH(EW), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_mode    (in_mode),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .correction (correction),
        .out_tag    (out_tag)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: output handshake completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got corr 0x%0h tag %0d with no request pending",
                         correction, out_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("corr_tag%0d", e.tag), {22'd0, correction}, {22'd0, e.corr});
                check($sformatf("tag_of_%0d", e.tag), {28'd0, out_tag}, {28'd0, e.tag});
            end
        end
    end

    task automatic cfg_write(input logic [AB-1:0] addr, input logic [EW-1:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(posedge clk); #1;
        cfg_we    = 1'b0;
    endtask

    // Presents one request; returns #1 after the edge at which it was accepted.
    task automatic lookup(input logic [AB+FB-1:0] x, input logic mode,
                          input logic [TW-1:0] tag, input logic [EW-1:0] exp_corr);
        int  waited = 0;
        bit  done   = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_mode  = mode;
        in_tag   = tag;
        while (!done) begin
            if (in_ready) begin
                sb.push_back('{corr: exp_corr, tag: tag});
                done = 1;
            end
            @(posedge clk); #1;
            if (!done) begin
                waited++;
                if (waited > 50) begin
                    check($sformatf("accept_timeout_tag%0d", tag), 32'd0, 32'd1);
                    done = 1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, sb.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; in_x = '0; in_mode = 1'b0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_correction", {22'd0, correction}, 32'd0);
        check("reset_out_tag", {28'd0, out_tag}, 32'd0);

        // Interpolation between T[2]=960 and T[3]=930 at frac 8 -> 945, with latency check.
        cfg_write(4'd2, 10'h3C0);
        cfg_write(4'd3, 10'h3A2);
        lookup(8'h28, 1'b1, 4'd5, 10'h3B1);
        @(posedge clk); #1 check("latency_n1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1 check("latency_n2", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1 check("latency_n3", {31'd0, out_valid}, 32'd1);
        drain("drain_t1");

        // Nearest-lower, frac=0, clamp at top, and several interpolation roundings.
        lookup(8'h28, 1'b0, 4'd6, 10'h3C0);
        lookup(8'h20, 1'b1, 4'd7, 10'h3C0);
        cfg_write(4'd15, 10'h26C);
        cfg_write(4'd0, 10'h3FF);
        lookup(8'hFF, 1'b1, 4'd8, 10'h26C);
        lookup(8'h2F, 1'b1, 4'd9, 10'h3A4);
        lookup(8'h38, 1'b1, 4'd10, 10'h1D1);
        lookup(8'hE4, 1'b1, 4'd11, 10'h09B);
        drain("drain_t2");

        // Backpressure: four requests fill the pipe, then output freezes.
        out_ready = 1'b0;
        lookup(8'h20, 1'b0, 4'd1, 10'h3C0);
        lookup(8'h28, 1'b1, 4'd2, 10'h3B1);
        lookup(8'h2F, 1'b1, 4'd3, 10'h3A4);
        lookup(8'h30, 1'b0, 4'd4, 10'h3A2);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("stall_in_ready_c%0d", i), {31'd0, in_ready}, 32'd0);
            check($sformatf("stall_valid_c%0d", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("stall_corr_c%0d", i), {22'd0, correction}, 32'h3C0);
            check($sformatf("stall_tag_c%0d", i), {28'd0, out_tag}, 32'd1);
        end
        out_ready = 1'b1;
        drain("drain_t4");

        // Table write in the same cycle as an accepted lookup reads the old entry.
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_wdata = 10'h100;
        lookup(8'h20, 1'b0, 4'd12, 10'h3C0);
        cfg_we = 1'b0;
        lookup(8'h20, 1'b0, 4'd13, 10'h100);
        drain("drain_t5");

        // Reset with three requests in flight: nothing emerges, table reads back zero.
        lookup(8'h28, 1'b1, 4'd1, 10'h3B1);
        lookup(8'h28, 1'b1, 4'd2, 10'h3B1);
        lookup(8'h28, 1'b1, 4'd3, 10'h3B1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("rst_quiet_c%0d", i), {31'd0, out_valid}, 32'd0);
        end
        lookup(8'h28, 1'b1, 4'd14, 10'h000);
        lookup(8'hFF, 1'b0, 4'd15, 10'h000);
        drain("drain_t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
